// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types for the decode-stage hazard unit.
// Tracked-entry layout, x0 constant and forward-select encoding.
package pipe_hazard_unit_pkg;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } hz_entry_t;

    localparam hz_entry_t ENTRY_BUBBLE = '0;

    // True when this in-flight entry will write the register rs reads.
    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic entry_writes(
        input hz_entry_t  e,
        input logic [4:0] rs
    );
        return e.valid && e.we && (e.rd == rs) && (rs != REG_X0);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_src_match.sv
// Per-source dependency search across the tracked stages.
// Reports whether any stage matches, the youngest one, and its readiness.
module hazard_src_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter  int DEPTH      = 3,
    parameter  int ALU_READY  = 1,
    parameter  int LOAD_READY = 2,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  hz_entry_t [DEPTH:1] entries,
    input  logic [4:0]          rs,
    input  logic                rs_used,
    output logic                match,
    output logic                ready,
    output logic [SEL_W-1:0]    sel
);

    // Walk oldest to youngest so the youngest matching stage wins.
    always_comb begin
        match = 1'b0;
        ready = 1'b0;
        sel   = SEL_W'(FWD_RF);
        if (rs_used) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (entry_writes(entries[k], rs)) begin
                    match = 1'b1;
                    sel   = SEL_W'(k);
                    ready = entries[k].is_load ? (k >= LOAD_READY)
                                               : (k >= ALU_READY);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard unit: forwarding selects, load-use stalls, flush.
// Tracks destination info of the instructions between EX and WB.
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter  int DEPTH      = 3,
    parameter  int ALU_READY  = 1,
    parameter  int LOAD_READY = 2,
    parameter  int FWD_EN     = 1,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [4:0]       dec_rd,
    input  logic             dec_rd_we,
    input  logic             dec_is_load,
    input  logic             redirect,
    output logic             stall_o,
    output logic             flush_o,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    hz_entry_t [DEPTH:1] entries;
    hz_entry_t           dec_entry;

    logic             a_match;
    logic             a_ready;
    logic [SEL_W-1:0] a_sel;
    logic             b_match;
    logic             b_ready;
    logic [SEL_W-1:0] b_sel;
    logic             a_block;
    logic             b_block;

    hazard_src_match #(
        .DEPTH      (DEPTH),
        .ALU_READY  (ALU_READY),
        .LOAD_READY (LOAD_READY)
    ) u_src_a (
        .entries (entries),
        .rs      (dec_rs1),
        .rs_used (dec_rs1_used),
        .match   (a_match),
        .ready   (a_ready),
        .sel     (a_sel)
    );

    hazard_src_match #(
        .DEPTH      (DEPTH),
        .ALU_READY  (ALU_READY),
        .LOAD_READY (LOAD_READY)
    ) u_src_b (
        .entries (entries),
        .rs      (dec_rs2),
        .rs_used (dec_rs2_used),
        .match   (b_match),
        .ready   (b_ready),
        .sel     (b_sel)
    );

    // Stall, flush and select decisions; redirect overrides any stall.
    always_comb begin
        if (FWD_EN != 0) begin
            a_block = a_match && !a_ready;
            b_block = b_match && !b_ready;
        end else begin
            a_block = a_match;
            b_block = b_match;
        end
        stall_o = dec_valid && !redirect && (a_block || b_block);
        flush_o = redirect;
        fwd_a_sel = SEL_W'(FWD_RF);
        fwd_b_sel = SEL_W'(FWD_RF);
        if (FWD_EN != 0 && dec_valid) begin
            if (a_match && a_ready) fwd_a_sel = a_sel;
            if (b_match && b_ready) fwd_b_sel = b_sel;
        end
        dec_entry = '{valid:   dec_valid,
                      rd:      dec_rd,
                      we:      dec_rd_we,
                      is_load: dec_is_load};
    end

    // Advance tracked stages; stalls inject a bubble, redirect kills all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries <= '0;
        end else begin
            entries[1] <= (stall_o || redirect) ? ENTRY_BUBBLE : dec_entry;
            for (int k = 2; k <= DEPTH; k++) begin
                entries[k] <= redirect ? ENTRY_BUBBLE : entries[k-1];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_o && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed scenarios plus random traffic.
// Three instances: forwarding, stall-only, stall-only with 2-bit counter.
module tb_pipe_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       dec_valid;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, rd_we, is_load;
    logic       redirect;

    logic [2:0]  st, fl;
    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_unit u0 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(rs1), .dec_rs2(rs2),
        .dec_rs1_used(rs1_used), .dec_rs2_used(rs2_used),
        .dec_rd(rd), .dec_rd_we(rd_we), .dec_is_load(is_load),
        .redirect(redirect), .stall_o(st[0]), .flush_o(fl[0]),
        .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .stall_cnt(cnt0)
    );

    pipe_hazard_unit #(.FWD_EN(0)) u1 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(rs1), .dec_rs2(rs2),
        .dec_rs1_used(rs1_used), .dec_rs2_used(rs2_used),
        .dec_rd(rd), .dec_rd_we(rd_we), .dec_is_load(is_load),
        .redirect(redirect), .stall_o(st[1]), .flush_o(fl[1]),
        .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .stall_cnt(cnt1)
    );

    pipe_hazard_unit #(.FWD_EN(0), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_rs1(rs1), .dec_rs2(rs2),
        .dec_rs1_used(rs1_used), .dec_rs2_used(rs2_used),
        .dec_rd(rd), .dec_rd_we(rd_we), .dec_is_load(is_load),
        .redirect(redirect), .stall_o(st[2]), .flush_o(fl[2]),
        .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]), .stall_cnt(cnt2)
    );

    // Reference model: history of decoded instructions by age (1 = EX).
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } rec_t;

    rec_t hist [3][4];
    int   mcnt [3];
    int   cmax [3] = '{65535, 65535, 3};
    bit   mfwd [3] = '{1'b1, 1'b0, 1'b0};

    function automatic int src_sel(int i, bit [4:0] rs, bit used,
                                   output bit blk);
        int need;
        blk = 1'b0;
        if (!used || rs == 0) return 0;
        for (int k = 1; k <= 3; k++) begin
            if (hist[i][k].v && hist[i][k].we && hist[i][k].rd == rs) begin
                need = hist[i][k].ld ? 2 : 1;
                if (!mfwd[i]) begin blk = 1'b1; return 0; end
                if (k >= need) return k;
                blk = 1'b1;
                return 0;
            end
        end
        return 0;
    endfunction

    function automatic void model_eval(int i, output bit s,
                                       output int sa, output int sb);
        bit ba, bb;
        sa = src_sel(i, rs1, rs1_used, ba);
        sb = src_sel(i, rs2, rs2_used, bb);
        s  = dec_valid && !redirect && (ba || bb);
        if (!dec_valid) begin sa = 0; sb = 0; end
    endfunction

    function automatic void model_clock(int i);
        bit s;
        int sa, sb;
        model_eval(i, s, sa, sb);
        if (s && mcnt[i] < cmax[i]) mcnt[i]++;
        hist[i][3] = hist[i][2];
        hist[i][2] = hist[i][1];
        if (s || redirect) hist[i][1] = '{1'b0, 5'd0, 1'b0, 1'b0};
        else hist[i][1] = '{dec_valid, rd, rd_we, is_load};
        if (redirect) for (int k = 1; k <= 3; k++) hist[i][k].v = 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mcnt[i] = 0;
            for (int k = 0; k < 4; k++) hist[i][k] = '{1'b0, 5'd0, 1'b0, 1'b0};
        end
    endfunction

    task automatic set_dec(input bit v, input bit [4:0] a, input bit ua,
                           input bit [4:0] b, input bit ub,
                           input bit [4:0] d, input bit we, input bit ld);
        dec_valid = v; rs1 = a; rs1_used = ua; rs2 = b; rs2_used = ub;
        rd = d; rd_we = we; is_load = ld; redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_clock(i);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        set_dec(1, 5, 1, 6, 1, 7, 1, 0);
        redirect = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (st[i] !== 1'b0) begin n_errors++; $display("FAIL rst_stall[%0d] got %b want 0", i, st[i]); end
            n_checks++; if (fl[i] !== 1'b1) begin n_errors++; $display("FAIL rst_flush[%0d] got %b want 1", i, fl[i]); end
            n_checks++; if (fa[i] !== 2'd0 || fb[i] !== 2'd0) begin n_errors++; $display("FAIL rst_sel[%0d] got %0d/%0d want 0/0", i, fa[i], fb[i]); end
        end
        n_checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 2'd0) begin n_errors++; $display("FAIL rst_cnt got %0d/%0d/%0d want 0", cnt0, cnt1, cnt2); end
        redirect = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_dec(1, 5, 1, 6, 1, 20, 1, 0);
        #2;
        n_checks++; if (st !== 3'b000) begin n_errors++; $display("FAIL first_dec_stall got %b want 000", st); end
        n_checks++; if (fl !== 3'b000) begin n_errors++; $display("FAIL first_dec_flush got %b want 000", fl); end
        n_checks++; if (fa[0] !== 2'd0 || fb[0] !== 2'd0) begin n_errors++; $display("FAIL first_dec_sel got %0d/%0d want 0/0", fa[0], fb[0]); end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_dec(1, 5, 1, 1, 1, 6, 1, 0);
        #2;
        n_checks++; if (st[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_stall got %b want 0", st[0]); end
        n_checks++; if (fa[0] !== 2'd1) begin n_errors++; $display("FAIL b2b_fwd_a got %0d want 1", fa[0]); end
        n_checks++; if (fb[0] !== 2'd0) begin n_errors++; $display("FAIL b2b_fwd_b got %0d want 0", fb[0]); end
        n_checks++; if (st[1] !== 1'b1) begin n_errors++; $display("FAIL b2b_nofwd_stall got %b want 1", st[1]); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        set_dec(1, 7, 1, 7, 1, 8, 1, 0);
        #2;
        n_checks++; if (st[0] !== 1'b1) begin n_errors++; $display("FAIL lu_stall got %b want 1", st[0]); end
        tick();
        n_checks++; if (cnt0 !== 16'd1) begin n_errors++; $display("FAIL lu_cnt got %0d want 1", cnt0); end
        #1;
        n_checks++; if (st[0] !== 1'b0) begin n_errors++; $display("FAIL lu_release got %b want 0", st[0]); end
        n_checks++; if (fa[0] !== 2'd2 || fb[0] !== 2'd2) begin n_errors++; $display("FAIL lu_fwd got %0d/%0d want 2/2", fa[0], fb[0]); end
        tick();
    endtask

    task automatic test_youngest();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 9, 1, 0);
        tick();
        set_dec(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        set_dec(1, 0, 0, 0, 0, 9, 1, 0);
        tick();
        set_dec(1, 9, 1, 0, 0, 4, 1, 0);
        #2;
        n_checks++; if (fa[0] !== 2'd1) begin n_errors++; $display("FAIL young_fwd_a got %0d want 1", fa[0]); end
        n_checks++; if (st[0] !== 1'b0) begin n_errors++; $display("FAIL young_stall got %b want 0", st[0]); end
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_dec(1, 0, 1, 0, 1, 1, 1, 0);
        #2;
        n_checks++; if (st !== 3'b000) begin n_errors++; $display("FAIL x0_stall got %b want 000", st); end
        n_checks++; if (fa[0] !== 2'd0 || fb[0] !== 2'd0) begin n_errors++; $display("FAIL x0_sel got %0d/%0d want 0/0", fa[0], fb[0]); end
        tick();
    endtask

    task automatic test_redirect();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 7, 1, 1);
        tick();
        set_dec(1, 7, 1, 7, 1, 8, 1, 0);
        redirect = 1'b1;
        #2;
        n_checks++; if (fl[0] !== 1'b1) begin n_errors++; $display("FAIL redir_flush got %b want 1", fl[0]); end
        n_checks++; if (st !== 3'b000) begin n_errors++; $display("FAIL redir_stall got %b want 000", st); end
        tick();
        redirect = 1'b0;
        #2;
        n_checks++; if (st !== 3'b000) begin n_errors++; $display("FAIL redir_cleared_stall got %b want 000", st); end
        n_checks++; if (fa[0] !== 2'd0 || fb[0] !== 2'd0) begin n_errors++; $display("FAIL redir_cleared_sel got %0d/%0d want 0/0", fa[0], fb[0]); end
        tick();
    endtask

    task automatic test_no_fwd();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_dec(1, 5, 1, 1, 1, 6, 1, 0);
        for (int c = 0; c < 4; c++) begin
            #2;
            n_checks++; if (st[1] !== (c < 3)) begin n_errors++; $display("FAIL nofwd_stall[%0d] got %b want %b", c, st[1], c < 3); end
            n_checks++; if (fa[1] !== 2'd0 || fb[1] !== 2'd0) begin n_errors++; $display("FAIL nofwd_sel[%0d] got %0d/%0d want 0/0", c, fa[1], fb[1]); end
            tick();
        end
        n_checks++; if (cnt1 !== 16'd3) begin n_errors++; $display("FAIL nofwd_cnt got %0d want 3", cnt1); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int p = 0; p < 2; p++) begin
            set_dec(1, 0, 0, 0, 0, 5'(10 + p), 1, 0);
            tick();
            set_dec(1, 5'(10 + p), 1, 0, 0, 12, 1, 0);
            for (int c = 0; c < 3 - p; c++) tick();
        end
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        n_checks++; if (cnt1 !== 16'd5) begin n_errors++; $display("FAIL sat_cnt16 got %0d want 5", cnt1); end
        n_checks++; if (cnt2 !== 2'd3) begin n_errors++; $display("FAIL sat_cnt2 got %0d want 3", cnt2); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_dec(1, 0, 0, 0, 0, 5, 1, 0);
        tick();
        set_dec(1, 5, 1, 0, 0, 6, 1, 0);
        tick();
        #2;
        n_checks++; if (st[1] !== 1'b1) begin n_errors++; $display("FAIL mid_pre_stall got %b want 1", st[1]); end
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++; if (st !== 3'b000) begin n_errors++; $display("FAIL mid_rst_stall got %b want 000", st); end
        n_checks++; if (cnt1 !== 16'd0 || cnt2 !== 2'd0) begin n_errors++; $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", cnt1, cnt2); end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random();
        bit s;
        int sa, sb;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            dec_valid = ($urandom_range(0, 9) < 8);
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            rs1_used = 1'($urandom);
            rs2_used = 1'($urandom);
            rd = 5'($urandom_range(0, 3));
            rd_we = ($urandom_range(0, 3) != 0);
            is_load = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 15) == 0);
            #2;
            for (int i = 0; i < 3; i++) begin
                model_eval(i, s, sa, sb);
                n_checks++; if (st[i] !== s) begin n_errors++; $display("FAIL rnd_stall[%0d] n=%0d got %b want %b", i, n, st[i], s); end
                n_checks++; if (fl[i] !== redirect) begin n_errors++; $display("FAIL rnd_flush[%0d] n=%0d got %b want %b", i, n, fl[i], redirect); end
                n_checks++; if (fa[i] !== 2'(sa) || fb[i] !== 2'(sb)) begin n_errors++; $display("FAIL rnd_sel[%0d] n=%0d got %0d/%0d want %0d/%0d", i, n, fa[i], fb[i], sa, sb); end
            end
            tick();
            n_checks++; if (cnt0 !== 16'(mcnt[0]) || cnt1 !== 16'(mcnt[1]) || cnt2 !== 2'(mcnt[2])) begin
                n_errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d/%0d want %0d/%0d/%0d", n, cnt0, cnt1, cnt2, mcnt[0], mcnt[1], mcnt[2]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        test_reset();
        test_back_to_back();
        test_load_use();
        test_youngest();
        test_x0();
        test_redirect();
        test_no_fwd();
        test_saturate();
        test_reset_mid_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
